// File: rtl/bus_arbiter_if.sv
// Requester-side bundle of the shared data bus arbiter.
// The master side drives requests and data; the slave side is the arbiter.
interface bus_arbiter_if #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 64
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        done;
  logic [N_REQ*DATA_W-1:0] bus_in;
  logic [N_REQ-1:0]        gnt;
  logic [DATA_W-1:0]       sharedBus;
  logic                    bus_valid;
  logic [OW-1:0]           owner;
  logic                    timeout_pulse;

  modport master (
    output req, done, bus_in,
    input  gnt, sharedBus, bus_valid, owner, timeout_pulse
  );

  modport slave (
    input  req, done, bus_in,
    output gnt, sharedBus, bus_valid, owner, timeout_pulse
  );
endinterface

// File: rtl/bus_arbiter.sv
// Round-robin arbiter for the shared data bus: hold limit,
// one turnaround cycle between owners, registered owner data.
module bus_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 64,
  parameter int MAX_HOLD = 16
) (
  input  logic         clkA,
  input  logic         reset,
  bus_arbiter_if.slave bus
);
  localparam int OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int HW = $clog2(MAX_HOLD);

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    TURN
  } state_e;

  state_e            state_q, state_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     own_q, own_d;
  logic [HW-1:0]     hold_q, hold_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic [DATA_W-1:0] bus_q, bus_d;
  logic              vld_q, vld_d;
  logic              tmo_q, tmo_d;

  logic [OW-1:0] win;
  logic          found;
  logic [OW:0]   sum;
  logic          any_req;
  logic          at_lim;
  logic          rel;

  assign any_req = |bus.req;
  assign at_lim  = (hold_q == HW'(MAX_HOLD - 1));
  assign rel     = bus.done[own_q] | ~bus.req[own_q] | at_lim;

  // search starts just past the last winner, so it goes last
  always_comb begin
    win   = ptr_q;
    found = 1'b0;
    sum   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      sum = {1'b0, ptr_q} + (OW+1)'(k);
      if (sum >= (OW+1)'(N_REQ)) sum = sum - (OW+1)'(N_REQ);
      if (!found && bus.req[sum[OW-1:0]]) begin
        win   = sum[OW-1:0];
        found = 1'b1;
      end
    end
  end

  always_ff @(posedge clkA or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= OW'(N_REQ - 1);
      own_q   <= '0;
      hold_q  <= '0;
      gnt_q   <= '0;
      bus_q   <= '0;
      vld_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      hold_q  <= hold_d;
      gnt_q   <= gnt_d;
      bus_q   <= bus_d;
      vld_q   <= vld_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = any_req ? GRANT : IDLE;
      GRANT:   state_d = rel ? TURN : GRANT;
      TURN:    state_d = any_req ? GRANT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ptr_d  = ptr_q;
    own_d  = own_q;
    hold_d = hold_q;
    gnt_d  = '0;
    tmo_d  = 1'b0;
    vld_d  = (state_q == GRANT);
    bus_d  = '0;
    if (vld_d) begin
      bus_d = bus.bus_in[int'(own_q)*DATA_W +: DATA_W];
    end
    if (state_d == GRANT) begin
      if (state_q == GRANT) begin
        hold_d = hold_q + 1'b1;
        gnt_d  = gnt_q;
      end else begin
        hold_d = '0;
        ptr_d  = win;
        own_d  = win;
        gnt_d  = N_REQ'(1) << win;
      end
    end
    // a release that coincides with the limit is not a timeout
    if (state_q == GRANT && state_d == TURN) begin
      tmo_d = at_lim & bus.req[own_q] & ~bus.done[own_q];
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.sharedBus     = bus_q;
  assign bus.bus_valid     = vld_q;
  assign bus.owner         = own_q;
  assign bus.timeout_pulse = tmo_q;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed and randomized bench for bus_arbiter against a
// cycle-level ownership model (who owns, for how long, why released).
module tb_bus_arbiter;
  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MH = 16;

  logic clkA  = 1'b0;
  logic reset = 1'b1;
  always #5 clkA = ~clkA;

  bus_arbiter_if #(.N_REQ(N), .DATA_W(W)) bif ();

  bus_arbiter #(
    .N_REQ(N),
    .DATA_W(W),
    .MAX_HOLD(MH)
  ) dut (
    .clkA (clkA),
    .reset(reset),
    .bus  (bif)
  );

  int checks   = 0;
  int failures = 0;

  int         m_own;
  int         m_hold;
  int         m_last;
  int         m_out;
  bit         m_tmo;
  bit         m_vld;
  logic [W-1:0] m_bus;

  function automatic int rr_pick(int last, logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(last + k) % N]) return (last + k) % N;
    return -1;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_own  = -1;
    m_hold = 0;
    m_last = N - 1;
    m_out  = 0;
    m_tmo  = 1'b0;
    m_vld  = 1'b0;
    m_bus  = '0;
  endtask

  task automatic model_edge();
    logic [N-1:0] r;
    logic [N-1:0] d;
    bit lim;
    r = bif.req;
    d = bif.done;
    m_vld = (m_own >= 0);
    m_bus = m_vld ? bif.bus_in[m_own*W +: W] : '0;
    m_tmo = 1'b0;
    if (m_own >= 0) begin
      lim = (m_hold + 1 == MH);
      if (d[m_own] || !r[m_own] || lim) begin
        m_tmo = lim && !d[m_own] && r[m_own];
        m_own = -1;
      end else begin
        m_hold++;
      end
    end else if (r != '0) begin
      m_own  = rr_pick(m_last, r);
      m_last = m_own;
      m_out  = m_own;
      m_hold = 0;
    end
  endtask

  task automatic check_all();
    logic [N-1:0] eg;
    eg = '0;
    if (m_own >= 0) eg[m_own] = 1'b1;
    chk("gnt", 64'(bif.gnt), 64'(eg));
    chk("sharedBus", bif.sharedBus, m_bus);
    chk("bus_valid", 64'(bif.bus_valid), 64'(m_vld));
    chk("owner", 64'(bif.owner), 64'(m_out));
    chk("timeout", 64'(bif.timeout_pulse), 64'(m_tmo));
    chk("onehot", 64'($onehot0(bif.gnt)), 64'd1);
    chk("gnt_tmo", 64'((|bif.gnt) & bif.timeout_pulse), 64'd0);
  endtask

  task automatic step();
    model_edge();
    @(posedge clkA);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    @(negedge clkA);
    reset = 1'b1;
  endtask

  int run, len, phase, cg, cv;
  bit gd, tto, regr;
  logic [N-1:0] prevg, nextg;
  int order[$];
  int exp_rr[5] = '{0, 1, 2, 3, 0};

  initial begin
    bif.req    = '0;
    bif.done   = '0;
    bif.bus_in = '0;
    #2;
    do_reset();

    // single requester, done on 4th grant cycle
    bif.bus_in[1*W +: W] = 64'hA5A5_0000_0000_0001;
    bif.req = 4'b0010;
    step();
    chk("single_gnt", 64'(bif.gnt), 64'h2);
    chk("single_owner", 64'(bif.owner), 64'd1);
    cg = 1; cv = 0; gd = 0;
    for (int i = 0; i < 5; i++) begin
      bif.done = (i == 3) ? 4'b0010 : 4'b0000;
      step();
      if (bif.gnt == 4'b0010 && !gd) cg++;
      else gd = 1;
      if (bif.bus_valid && bif.sharedBus == 64'hA5A5_0000_0000_0001) cv++;
    end
    bif.done = '0;
    chk("single_gnt_len", 64'(cg), 64'd4);
    chk("single_vld_len", 64'(cv), 64'd4);
    bif.req = '0;
    step();
    step();

    // round-robin, done on 2nd grant cycle
    do_reset();
    bif.req = 4'b1111;
    run = 0; prevg = '0; order = {};
    for (int i = 0; i < 40; i++) begin
      if (order.size() < 5) begin
        bif.done = (run == 2) ? bif.gnt : 4'b0000;
        step();
        if (bif.gnt != '0) begin
          if (prevg == '0) begin
            order.push_back(int'(bif.owner));
            run = 1;
          end else run++;
        end else run = 0;
        prevg = bif.gnt;
      end
    end
    bif.done = '0;
    chk("rr_count", 64'(order.size()), 64'd5);
    for (int k = 0; k < 5; k++)
      if (k < order.size()) chk("rr_order", 64'(order[k]), 64'(exp_rr[k]));
    bif.req = '0;
    step();

    // timeout of a lone requester
    do_reset();
    bif.req = 4'b0100;
    run = 0; len = 0; phase = 0; tto = 0; regr = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (bif.gnt == 4'b0100) begin
        if (phase == 0) run++;
        else if (phase == 1) begin regr = 1; phase = 2; end
      end else if (phase == 0 && run > 0) begin
        len = run; phase = 1; tto = bif.timeout_pulse;
      end
    end
    chk("to_len", 64'(len), 64'(MH));
    chk("to_pulse", 64'(tto), 64'd1);
    chk("to_regrant", 64'(regr), 64'd1);
    bif.req = '0;
    step();

    // timeout fairness: 3 served before 0 returns
    do_reset();
    bif.req = 4'b0001;
    run = 0; phase = 0; tto = 0; nextg = '0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (phase == 0) begin
        if (bif.gnt == 4'b0001) begin
          run++;
          if (run == 5) bif.req = 4'b1001;
        end else if (run > 0) begin
          phase = 1; tto = bif.timeout_pulse;
        end
      end else if (phase == 1 && bif.gnt != '0) begin
        nextg = bif.gnt; phase = 2;
      end
    end
    chk("fair_tmo", 64'(tto), 64'd1);
    chk("fair_next", 64'(nextg), 64'h8);
    bif.req = '0;
    step();

    // done coinciding with the limit; foreign done ignored
    do_reset();
    bif.req = 4'b0001;
    run = 0; phase = 0; len = 0; tto = 1;
    for (int i = 0; i < 30; i++) begin
      bif.done = 4'b0000;
      if (phase == 0 && run == 3)  bif.done = 4'b0010;
      if (phase == 0 && run == MH) bif.done = 4'b0001;
      step();
      if (phase == 0) begin
        if (bif.gnt == 4'b0001) run++;
        else if (run > 0) begin
          phase = 1; len = run; tto = bif.timeout_pulse;
        end
      end
    end
    bif.done = '0;
    chk("coin_len", 64'(len), 64'(MH));
    chk("coin_tmo", 64'(tto), 64'd0);
    bif.req = '0;
    step();

    // reset asserted mid-grant
    do_reset();
    bif.req = 4'b0100;
    step();
    step();
    step();
    chk("rm_gnt3", 64'(bif.gnt), 64'h4);
    reset = 1'b0;
    #1;
    model_reset();
    check_all();
    chk("rm_gnt0", 64'(bif.gnt), 64'd0);
    chk("rm_vld0", 64'(bif.bus_valid), 64'd0);
    bif.req = 4'b0110;
    @(negedge clkA);
    reset = 1'b1;
    step();
    chk("rm_first", 64'(bif.gnt), 64'h2);
    bif.req = '0;
    step();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 5) == 0) bif.req[b] = ~bif.req[b];
      bif.done = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
      for (int k = 0; k < N*W/32; k++)
        bif.bus_in[k*32 +: 32] = $urandom;
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
